// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register placed directly after reg_bank.
//   - Captures the rs/rt operands from reg_bank. EX/MEM and WB results are
//     bypassed at capture, because reg_bank returns the old value when it is
//     read in the same cycle that it writes.
//   - Sign-extends the 16-bit immediate and registers the decoded control.
//   - Detects load-use hazards. It raises stall (combinational) toward IF/ID
//     and inserts a bubble into EX.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   id_valid, rs/rt/rd_addr           decoded instruction in ID
//   rs_data, rt_data                  reg_bank read ports a/b
//   imm, uses_rt, reg_dst, ctl_*      immediate and decoded control
//   flush                             squashes the ID instruction
//   exmem_*, wb_*                     bypass sources (EX/MEM, write-back)
//   stall                             IF/ID must hold
//   ex_*                              registered EX-stage state
//   stall_count                       saturating count of stall cycles
module id_ex_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  rs_addr,
    input  logic [REG_ADDR_W-1:0]  rt_addr,
    input  logic [REG_ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]      rs_data,
    input  logic [DATA_W-1:0]      rt_data,
    input  logic [15:0]            imm,
    input  logic                   uses_rt,
    input  logic                   reg_dst,
    input  logic                   ctl_reg_write,
    input  logic                   ctl_mem_read,
    input  logic                   ctl_mem_write,
    input  logic                   ctl_alu_src,
    input  logic [3:0]             ctl_alu_op,
    input  logic                   flush,
    input  logic                   exmem_reg_write,
    input  logic [REG_ADDR_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0]      exmem_data,
    input  logic                   wb_reg_write,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   stall,
    output logic                   ex_valid,
    output logic [DATA_W-1:0]      ex_rs_val,
    output logic [DATA_W-1:0]      ex_rt_val,
    output logic [DATA_W-1:0]      ex_imm,
    output logic [REG_ADDR_W-1:0]  ex_rs_addr,
    output logic [REG_ADDR_W-1:0]  ex_rt_addr,
    output logic [REG_ADDR_W-1:0]  ex_dest,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_alu_src,
    output logic [3:0]             ex_alu_op,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     rs_sel;
    logic [DATA_W-1:0]     rt_sel;

    // $0 always reads as zero. EX/MEM is younger than WB, so it wins.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [DATA_W-1:0]     bank,
        input logic                  em_we,
        input logic [REG_ADDR_W-1:0] em_rd,
        input logic [DATA_W-1:0]     em_data,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic [DATA_W-1:0]     w_data
    );
        logic [DATA_W-1:0] r;
        r = bank;
        if (addr == '0)
            r = '0;
        else if (em_we && (em_rd == addr))
            r = em_data;
        else if (w_we && (w_rd == addr))
            r = w_data;
        return r;
    endfunction

    always_comb begin
        dest   = reg_dst ? rd_addr : rt_addr;
        // Only a load in EX creates a hazard. EX forwarding resolves every
        // other dependency.
        stall  = id_valid && ex_valid && ex_mem_read && (ex_dest != '0) &&
                 ((ex_dest == rs_addr) || (uses_rt && (ex_dest == rt_addr)));
        rs_sel = pick_operand(rs_addr, rs_data, exmem_reg_write, exmem_rd,
                              exmem_data, wb_reg_write, wb_rd, wb_data);
        rt_sel = pick_operand(rt_addr, rt_data, exmem_reg_write, exmem_rd,
                              exmem_data, wb_reg_write, wb_rd, wb_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_rs_val    <= '0;
            ex_rt_val    <= '0;
            ex_imm       <= '0;
            ex_rs_addr   <= '0;
            ex_rt_addr   <= '0;
            ex_dest      <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_alu_op    <= '0;
            stall_count  <= '0;
        end else begin
            if (stall && (stall_count != '1))
                stall_count <= stall_count + STALL_CNT_W'(1);

            if (flush || stall) begin
                ex_valid     <= 1'b0;
                ex_rs_val    <= '0;
                ex_rt_val    <= '0;
                ex_imm       <= '0;
                ex_rs_addr   <= '0;
                ex_rt_addr   <= '0;
                ex_dest      <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_alu_src   <= 1'b0;
                ex_alu_op    <= '0;
            end else begin
                ex_valid     <= id_valid;
                ex_rs_val    <= rs_sel;
                ex_rt_val    <= rt_sel;
                ex_imm       <= {{(DATA_W-16){imm[15]}}, imm};
                ex_rs_addr   <= rs_addr;
                ex_rt_addr   <= rt_addr;
                ex_dest      <= dest;
                // An empty ID slot must not carry side effects into EX.
                ex_reg_write <= id_valid & ctl_reg_write;
                ex_mem_read  <= id_valid & ctl_mem_read;
                ex_mem_write <= id_valid & ctl_mem_write;
                ex_alu_src   <= id_valid & ctl_alu_src;
                ex_alu_op    <= id_valid ? ctl_alu_op : 4'd0;
            end
        end
    end

endmodule
